// File: rtl/alu_pkg.sv
// alu_pkg: op/state encodings and 1-bit slice control decode shared by the serial ALU
package alu_pkg;
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [1:0] SEL_AND = 2'd0;
    localparam logic [1:0] SEL_OR  = 2'd1;
    localparam logic [1:0] SEL_SUM = 2'd2;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_FIN = 2'd2} state_t;
    typedef struct packed {
        logic       ainv;
        logic       binv;
        logic       cin;
        logic [1:0] sel;
    } ctl_t;
    function automatic ctl_t decode(input logic [2:0] op);
        ctl_t c;
        c.ainv = op == OP_NOR;
        c.binv = op inside {OP_SUB, OP_SLT, OP_NOR};
        c.cin  = op inside {OP_SUB, OP_SLT};
        c.sel  = op == OP_OR ? SEL_OR : op inside {OP_ADD, OP_SUB, OP_SLT} ? SEL_SUM : SEL_AND;
        return c;
    endfunction
endpackage

// File: rtl/alu_slice.sv
// alu_slice: combinational 1-bit ALU slice (AND/OR/full-add with operand inversion)
module alu_slice
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       ainv,
    input  logic       binv,
    input  logic       cin,
    input  logic [1:0] sel,
    output logic       res,
    output logic       cout
);
    logic aa, bb;
    always_comb begin
        aa   = a ^ ainv;
        bb   = b ^ binv;
        cout = (aa & bb) | (aa & cin) | (bb & cin);
        res  = sel == SEL_AND ? aa & bb : sel == SEL_OR ? aa | bb : aa ^ bb ^ cin;
    end
endmodule

// File: rtl/alu_serial.sv
// alu_serial: bit-serial ALU, one bit per clock through a single alu_slice, done pulse on completion
module alu_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             illegal_op
);
    localparam int CNT_W = $clog2(WIDTH);
    state_t state, state_n;
    ctl_t dec;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] ra, rb, sh, fin_res;
    logic [2:0] op_r;
    logic [1:0] sel_r;
    logic ainv_r, binv_r, carry, ovf, s_res, s_cout, last, arith, illegal;

    alu_slice u_slice (
        .a(ra[0]), .b(rb[0]), .ainv(ainv_r), .binv(binv_r), .cin(carry), .sel(sel_r),
        .res(s_res), .cout(s_cout)
    );

    assign dec = decode(op);
    assign busy = state != ST_IDLE;
    assign last = cnt == CNT_W'(WIDTH - 1);
    assign arith = op_r inside {OP_ADD, OP_SUB, OP_SLT};
    assign illegal = op_r inside {3'b110, 3'b111};
    // SLT reports the true signed less-than: sign of a-b corrected by overflow
    assign fin_res = illegal ? '0 : op_r == OP_SLT ? {{(WIDTH-1){1'b0}}, sh[WIDTH-1] ^ ovf} : sh;

    always_comb begin
        state_n = state == ST_IDLE ? (start ? ST_RUN : ST_IDLE) :
                  state == ST_RUN  ? (last ? ST_FIN : ST_RUN) : ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            ra <= '0;
            rb <= '0;
            sh <= '0;
            op_r <= '0;
            ainv_r <= 1'b0;
            binv_r <= 1'b0;
            sel_r <= '0;
            carry <= 1'b0;
            ovf <= 1'b0;
            done <= 1'b0;
            result <= '0;
            carry_out <= 1'b0;
            overflow <= 1'b0;
            zero <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE && start) begin
                ra <= a;
                rb <= b;
                op_r <= op;
                ainv_r <= dec.ainv;
                binv_r <= dec.binv;
                sel_r <= dec.sel;
                carry <= dec.cin;
                cnt <= '0;
            end
            if (state == ST_RUN) begin
                sh <= {s_res, sh[WIDTH-1:1]};
                ra <= ra >> 1;
                rb <= rb >> 1;
                carry <= s_cout;
                cnt <= cnt + CNT_W'(1);
                if (last) ovf <= carry ^ s_cout;
            end
            if (state == ST_FIN) begin
                result <= fin_res;
                carry_out <= arith & carry;
                overflow <= arith & ovf;
                zero <= fin_res == '0;
                illegal_op <= illegal;
                done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_serial.sv
// tb_alu_serial: directed vectors at WIDTH=8 plus model-checked sweeps at WIDTH=2 and WIDTH=32
module tb_alu_serial;
    import alu_pkg::*;
    logic clk = 1'b0, rst = 1'b1;
    logic start8 = 1'b0, start2 = 1'b0, start32 = 1'b0;
    logic [2:0] op = '0;
    logic [63:0] a = '0, b = '0;
    logic busy8, done8, cy8, ov8, z8, il8;
    logic busy2, done2, cy2, ov2, z2, il2;
    logic busy32, done32, cy32, ov32, z32, il32;
    logic [7:0] res8;
    logic [1:0] res2;
    logic [31:0] res32;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    alu_serial #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op), .a(a[7:0]), .b(b[7:0]),
        .busy(busy8), .done(done8), .result(res8), .carry_out(cy8), .overflow(ov8),
        .zero(z8), .illegal_op(il8)
    );
    alu_serial #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .op(op), .a(a[1:0]), .b(b[1:0]),
        .busy(busy2), .done(done2), .result(res2), .carry_out(cy2), .overflow(ov2),
        .zero(z2), .illegal_op(il2)
    );
    alu_serial #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .start(start32), .op(op), .a(a[31:0]), .b(b[31:0]),
        .busy(busy32), .done(done32), .result(res32), .carry_out(cy32), .overflow(ov32),
        .zero(z32), .illegal_op(il32)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic dn(input int w);
        return w == 2 ? done2 : w == 32 ? done32 : done8;
    endfunction
    function automatic logic bz(input int w);
        return w == 2 ? busy2 : w == 32 ? busy32 : busy8;
    endfunction
    function automatic logic [63:0] rd(input int w);
        return w == 2 ? 64'(res2) : w == 32 ? 64'(res32) : 64'(res8);
    endfunction
    function automatic logic [3:0] fl(input int w);
        return w == 2 ? {cy2, ov2, z2, il2} : w == 32 ? {cy32, ov32, z32, il32} : {cy8, ov8, z8, il8};
    endfunction

    task automatic drive(input int w, input logic v);
        if (w == 2) start2 = v;
        else if (w == 32) start32 = v;
        else start8 = v;
    endtask

    // flags are packed as {carry_out, overflow, zero, illegal_op}
    function automatic void model(input int w, input logic [2:0] o, input logic [63:0] x, input logic [63:0] y,
                                  output logic [63:0] r, output logic [3:0] f);
        logic [64:0] s;
        logic [63:0] m, am, bm;
        logic cy, ov, il;
        m = (64'd1 << w) - 64'd1;
        am = x & m;
        bm = y & m;
        cy = 1'b0;
        ov = 1'b0;
        il = 1'b0;
        r = '0;
        case (o)
            3'd0: r = am & bm;
            3'd1: r = am | bm;
            3'd4: r = ~(am | bm) & m;
            3'd2, 3'd3, 3'd5: begin
                s = {1'b0, am} + (o == 3'd2 ? {1'b0, bm} : {1'b0, ~bm & m}) + (o == 3'd2 ? 65'd0 : 65'd1);
                r = s[63:0] & m;
                cy = s[w];
                ov = (am[w-1] == (o == 3'd2 ? bm[w-1] : ~bm[w-1])) && (r[w-1] != am[w-1]);
                if (o == 3'd5) r = {63'd0, r[w-1] ^ ov};
            end
            default: il = 1'b1;
        endcase
        f = {cy, ov, r == '0, il};
    endfunction

    task automatic do_op(input int w, input logic [2:0] o, input logic [63:0] x, input logic [63:0] y,
                         output logic [63:0] r, output logic [3:0] f, output int lat);
        @(negedge clk);
        op = o;
        a = x;
        b = y;
        drive(w, 1'b1);
        @(negedge clk);
        drive(w, 1'b0);
        a = ~x;
        b = ~y;
        op = ~o;
        check($sformatf("w%0d_busy", w), bz(w), 1);
        lat = 1;
        while (!dn(w) && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        r = rd(w);
        f = fl(w);
    endtask

    task automatic sweep(input int w, input int n);
        logic [63:0] r, er, x, y;
        logic [3:0] f, ef;
        logic [2:0] o;
        int lat;
        for (int i = 0; i < n; i++) begin
            o = 3'($urandom_range(0, 7));
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            model(w, o, x, y, er, ef);
            do_op(w, o, x, y, r, f, lat);
            check($sformatf("w%0d_%0d_op%0d_lat", w, i, o), 64'(lat), 64'(w + 2));
            check($sformatf("w%0d_%0d_op%0d_res", w, i, o), r, er);
            check($sformatf("w%0d_%0d_op%0d_flags", w, i, o), 64'(f), 64'(ef));
        end
    endtask

    initial begin
        logic [63:0] r;
        logic [3:0] f;
        int lat, nd;
        repeat (3) @(negedge clk);
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_result", res8, 0);
        check("rst_flags", {cy8, ov8, z8, il8}, 0);
        rst = 1'b0;

        do_op(8, OP_ADD, 64'hFF, 64'h01, r, f, lat);
        check("add_lat", lat, 10);
        check("add_res", r, 64'h00);
        check("add_flags", f, 4'b1010);
        @(negedge clk);
        check("add_done_width", done8, 0);
        check("add_hold", res8, 8'h00);

        do_op(8, OP_SUB, 64'h80, 64'h01, r, f, lat);
        check("sub_res", r, 64'h7F);
        check("sub_flags", f, 4'b1100);
        do_op(8, OP_SLT, 64'hFE, 64'h01, r, f, lat);
        check("slt_neg_res", r, 64'h01);
        do_op(8, OP_SLT, 64'h01, 64'hFE, r, f, lat);
        check("slt_pos_res", r, 64'h00);
        check("slt_pos_zero", f[1], 1);
        do_op(8, OP_NOR, 64'h0F, 64'h33, r, f, lat);
        check("nor_res", r, 64'hC0);
        check("nor_flags", f, 4'b0000);
        do_op(8, 3'b110, 64'hFF, 64'hFF, r, f, lat);
        check("ill_res", r, 64'h00);
        check("ill_flags", f, 4'b0011);

        // start held high with changing operands, then a fresh op accepted in the done cycle
        @(negedge clk);
        op = OP_ADD;
        a = 64'h01;
        b = 64'h02;
        start8 = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            a = 64'(lat * 17);
            b = 64'(lat * 5);
            op = OP_SUB;
        end while (!done8 && lat < 40);
        check("hold_lat", lat, 10);
        check("hold_res", res8, 8'h03);
        op = OP_SUB;
        a = 64'h10;
        b = 64'h03;
        @(negedge clk);
        start8 = 1'b0;
        lat = 1;
        while (!done8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_lat", lat, 10);
        check("b2b_res", res8, 8'h0D);
        check("b2b_cy", cy8, 1);

        // reset while bit 3 is being processed
        @(negedge clk);
        op = OP_ADD;
        a = 64'h55;
        b = 64'h22;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_busy", busy8, 0);
        check("rstmid_out", {done8, res8, cy8, ov8, z8, il8}, 0);
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) nd++;
        end
        check("rstmid_no_done", nd, 0);
        do_op(8, OP_ADD, 64'h12, 64'h34, r, f, lat);
        check("post_rst_lat", lat, 10);
        check("post_rst_res", r, 64'h46);

        sweep(2, 24);
        sweep(32, 24);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
